alu_op_sequencer: RTL and testbench

Program-driven controller for the 4-bit ALU / 8-bit accumulator-register datapath. Holds a small writable program of ALU operations and runs it one operation per cycle after a `start` request. Drives the ALU select and data inputs, plus the clear and load enables of the result register. Can repeat the program up to four times and reports completion with a `busy`/`done` handshake; it sits between the switch/key front end and the datapath.

---
 rtl/alu_op_sequencer.sv | 133 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Program-driven sequencer for the 4-bit ALU / 8-bit result-register datapath.
// Latency: start accepted at edge T -> CLEAR in T+1, EXEC from T+2, one entry per cycle, DONE after the last pass.
// Backpressure: none; start and prog_we are honoured only in IDLE, abort cancels a run in CLEAR/EXEC.
//
// Ports:
//   clk, reset          single rising-edge clock, synchronous active-high reset
//   prog_we/addr/entry  program write port, entry = {last, op[2:0], data[3:0]}
//   start, reps, abort  run request, repeat count (reps+1 passes), run cancel
//   alu_select/data     ALU operation and operand, driven only in EXEC
//   reg_clear/load      result-register enables
//   busy, done, pc      run status and current entry index
module alu_op_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [7:0]    prog_entry,
  input  logic          start,
  input  logic [1:0]    reps,
  input  logic          abort,
  output logic [2:0]    alu_select,
  output logic [3:0]    alu_data,
  output logic          reg_clear,
  output logic          reg_load,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] pc_nxt;
  logic [1:0]    loops_left, loops_nxt;
  logic [7:0]    mem [DEPTH];
  logic [7:0]    entry;
  logic          end_of_pass;

  // Asynchronous read of the entry addressed by pc.
  assign entry       = mem[pc];
  assign end_of_pass = entry[7] || (pc == AW'(DEPTH - 1));

  // Program storage; only writable while idle so a running program is stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (prog_we && (state == S_IDLE)) begin
      mem[prog_addr] <= prog_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= '0;
      loops_left <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      loops_left <= loops_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    loops_nxt  = loops_left;
    alu_select = '0;
    alu_data   = '0;
    reg_clear  = 1'b0;
    reg_load   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          loops_nxt = reps;
          pc_nxt    = '0;
          state_nxt = S_CLEAR;
        end
      end

      S_CLEAR: begin
        busy      = 1'b1;
        reg_clear = 1'b1;
        state_nxt = abort ? S_IDLE : S_EXEC;
      end

      S_EXEC: begin
        busy       = 1'b1;
        alu_select = entry[6:4];
        alu_data   = entry[3:0];
        if (abort) begin
          // The only input-to-output path: an aborted entry must not be
          // loaded, so the load enable is gated in the same cycle. pc holds.
          state_nxt = S_IDLE;
        end else begin
          reg_load = 1'b1;
          if (end_of_pass) begin
            if (loops_left == 2'd0) begin
              state_nxt = S_DONE;
            end else begin
              // Next pass accumulates onto the register; no re-clear.
              loops_nxt = loops_left - 2'd1;
              pc_nxt    = '0;
            end
          end else begin
            pc_nxt = pc + AW'(1);
          end
        end
      end

      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with an attached add-only datapath model.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Each comparison is an immediate assertion that counts and reports failures.
module tb_alu_op_sequencer;

  logic       clk;
  logic       reset;
  logic       prog_we;
  logic [2:0] prog_addr;
  logic [7:0] prog_entry;
  logic       start;
  logic [1:0] reps;
  logic       abort;
  logic [2:0] alu_select;
  logic [3:0] alu_data;
  logic       reg_clear;
  logic       reg_load;
  logic       busy;
  logic       done;
  logic [2:0] pc;

  logic [7:0] acc;
  int         tests;
  int         fails;

  alu_op_sequencer #(.DEPTH(8), .AW(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_entry (prog_entry),
    .start      (start),
    .reps       (reps),
    .abort      (abort),
    .alu_select (alu_select),
    .alu_data   (alu_data),
    .reg_clear  (reg_clear),
    .reg_load   (reg_load),
    .busy       (busy),
    .done       (done),
    .pc         (pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Result register fed by the ALU; op 000 adds the operand to the register.
  always @(posedge clk) begin
    if (reset || reg_clear) acc <= 8'h00;
    else if (reg_load && alu_select == 3'b000) acc <= acc + {4'h0, alu_data};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed view of all outputs: {sel,data,clr,load,busy,done,pc}.
  function automatic logic [15:0] outs();
    return {2'b00, alu_select, alu_data, reg_clear, reg_load, busy, done, pc};
  endfunction

  function automatic logic [15:0] exec_vec(input logic [3:0] d, input logic [2:0] p);
    return {2'b00, 3'b000, d, 1'b0, 1'b1, 1'b1, 1'b0, p};
  endfunction

  logic [3:0] seq_data [6];
  logic [2:0] seq_pc   [6];

  initial begin
    tests = 0;
    fails = 0;
    acc = 8'h00;
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_entry = '0;
    start = 1'b0; reps = '0; abort = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Idle after reset: every output zero.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_outs", outs(), 16'h0000);
    end

    // All-zero program, reps=0: 1 CLEAR, 8 EXEC of (0,0), then DONE.
    start = 1'b1; reps = 2'd0;
    tick();
    start = 1'b0;
    chk("zero_clear", outs(), {9'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0});
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("zero_exec", outs(), exec_vec(4'h0, 3'(i)));
    end
    tick();
    chk("zero_done", outs(), {9'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7});
    tick();
    chk("zero_idle", outs(), {13'b0, 3'd7});

    // Program {0: op000 d3}, {1: last op000 d5}.
    prog_we = 1'b1; prog_addr = 3'd0; prog_entry = 8'h03;
    tick();
    prog_addr = 3'd1; prog_entry = 8'h85;
    tick();
    prog_we = 1'b0;

    // reps=0: EXEC (0,3),(0,5); register 0x00, 0x03, 0x08 at done.
    start = 1'b1; reps = 2'd0;
    tick();
    start = 1'b0;
    chk("p1_clear", {15'b0, reg_clear}, 16'h1);
    tick();
    chk("p1_e0", outs(), exec_vec(4'h3, 3'd0));
    chk("p1_acc0", {8'h00, acc}, 16'h0000);
    tick();
    chk("p1_e1", outs(), exec_vec(4'h5, 3'd1));
    chk("p1_acc1", {8'h00, acc}, 16'h0003);
    tick();
    chk("p1_done", {14'b0, busy, done}, 16'h1);
    chk("p1_acc2", {8'h00, acc}, 16'h0008);
    tick();
    chk("p1_idle", {14'b0, busy, done}, 16'h0);

    // reps=2: six entries 3,5,3,5,3,5; register ends at 0x18; done at T+8.
    seq_data[0] = 4'h3; seq_data[1] = 4'h5; seq_data[2] = 4'h3;
    seq_data[3] = 4'h5; seq_data[4] = 4'h3; seq_data[5] = 4'h5;
    seq_pc[0] = 3'd0; seq_pc[1] = 3'd1; seq_pc[2] = 3'd0;
    seq_pc[3] = 3'd1; seq_pc[4] = 3'd0; seq_pc[5] = 3'd1;
    start = 1'b1; reps = 2'd2;
    tick();
    start = 1'b0;
    chk("r2_clear", {15'b0, reg_clear}, 16'h1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("r2_exec", outs(), exec_vec(seq_data[i], seq_pc[i]));
    end
    tick();
    chk("r2_done", {13'b0, busy, done, 1'b0}, 16'h2);
    chk("r2_acc", {8'h00, acc}, 16'h0018);
    tick();

    // Abort on the 2nd EXEC cycle: no load, IDLE next, pc holds, no done.
    start = 1'b1; reps = 2'd2;
    tick();
    start = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    #1;
    chk("ab_noload", {15'b0, reg_load}, 16'h0);
    chk("ab_data", {12'b0, alu_data}, 16'h5);
    tick();
    abort = 1'b0;
    chk("ab_idle", outs(), {13'b0, 3'd1});
    chk("ab_acc", {8'h00, acc}, 16'h0003);
    tick();
    chk("ab_nodone", {15'b0, done}, 16'h0);

    // prog_we during a run is ignored.
    start = 1'b1; reps = 2'd0;
    tick();
    start = 1'b0;
    prog_we = 1'b1; prog_addr = 3'd1; prog_entry = 8'hFF;
    tick();
    tick();
    chk("we_busy_e1", outs(), exec_vec(4'h5, 3'd1));
    prog_we = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("we_rerun_e1", outs(), exec_vec(4'h5, 3'd1));
    tick();
    tick();

    // prog_we and start together in IDLE: new entry 0 = last, d1.
    prog_we = 1'b1; prog_addr = 3'd0; prog_entry = 8'h81;
    start = 1'b1; reps = 2'd0;
    tick();
    prog_we = 1'b0; start = 1'b0;
    tick();
    chk("ws_exec", outs(), exec_vec(4'h1, 3'd0));
    tick();
    chk("ws_done", outs(), {9'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0});
    tick();

    // Reset on the 3rd EXEC cycle, then a fresh run sees zeroed memory.
    prog_we = 1'b1; prog_addr = 3'd0; prog_entry = 8'h03;
    tick();
    prog_we = 1'b0;
    start = 1'b1; reps = 2'd2;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("rs_e3", outs(), exec_vec(4'h3, 3'd0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs_idle", outs(), 16'h0000);
    start = 1'b1; reps = 2'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rs_exec", outs(), exec_vec(4'h0, 3'(i)));
    end
    tick();
    chk("rs_done", outs(), {9'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7});
    chk("rs_acc", {8'h00, acc}, 16'h0000);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
